button_conditioner: RTL

Front-end input block for the whack-a-mole game. It takes the four raw, asynchronous push-button pins and delivers what the game FSM consumes on its button ports:
- clean, synchronised debounced levels (`btn_level`);
- one-cycle press/release pulses per channel;
- a small press summary: any press, lowest pressed index, and a multi-press flag.

It sits between the board pins and the game core, in the same clock domain as the game core.

---
 rtl/button_conditioner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: four-channel push-button front end for the game core.
// Each raw pad goes through a two-flop synchroniser, then a per-channel
// debounce FSM that accepts a level change only after DEBOUNCE_CYCLES
// consecutive agreeing samples. Registered one-cycle press/release pulses
// and a combinational press summary are produced from the debounced levels.
//
// Handshake: there is none. Every output is a plain level or a one-cycle
// pulse, valid on every clock; the consumer must sample each cycle and the
// block never stalls.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_press,
  output logic [1:0] press_id,
  output logic       multi_press
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    ARM_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    ARM_LOW     = 2'd3
  } state_t;

  // Count value on which the candidate level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [3:0]       s1;
  logic [3:0]       s2;
  // Per-channel FSM state, kept as a named array so checkers can bind to it.
  state_t           chan_state [4];
  state_t           state_d    [4];
  logic [CNT_W-1:0] cnt_q      [4];
  logic [CNT_W-1:0] cnt_d      [4];
  logic [3:0]       press_d;
  logic [3:0]       release_d;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // State register: FSM state, debounce counters and the registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        chan_state[i] <= STABLE_LOW;
        cnt_q[i]      <= '0;
      end
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        chan_state[i] <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
      end
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  // Next-state logic: arm on a disagreeing sample, fall back on any glitch,
  // commit once the count of agreeing samples reaches DEBOUNCE_CYCLES.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = chan_state[i];
      cnt_d[i]   = cnt_q[i];
      case (chan_state[i])
        STABLE_LOW: begin
          if (s2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = STABLE_HIGH;
              press_d[i] = 1'b1;
            end else begin
              state_d[i] = ARM_HIGH;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        ARM_HIGH: begin
          if (!s2[i]) begin
            state_d[i] = STABLE_LOW;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE_HIGH;
            cnt_d[i]   = CNT_ZERO;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s2[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i]   = STABLE_LOW;
              release_d[i] = 1'b1;
            end else begin
              state_d[i] = ARM_LOW;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        ARM_LOW: begin
          if (s2[i]) begin
            state_d[i] = STABLE_HIGH;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = STABLE_LOW;
            cnt_d[i]     = CNT_ZERO;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE_LOW;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs: debounced level follows the FSM state; summary decodes the
  // registered press pulses so it lines up with them.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      btn_level[i] = (chan_state[i] == STABLE_HIGH) || (chan_state[i] == ARM_LOW);
    end
    any_press = |btn_press;
    if (btn_press[0])      press_id = 2'd0;
    else if (btn_press[1]) press_id = 2'd1;
    else if (btn_press[2]) press_id = 2'd2;
    else if (btn_press[3]) press_id = 2'd3;
    else                   press_id = 2'd0;
    multi_press = (btn_press[0] & btn_press[1]) | (btn_press[0] & btn_press[2]) |
                  (btn_press[0] & btn_press[3]) | (btn_press[1] & btn_press[2]) |
                  (btn_press[1] & btn_press[3]) | (btn_press[2] & btn_press[3]);
  end

endmodule
